// File: rtl/count_pkg.sv
// Shared types and constants for the count_bcd binary-to-BCD converter.
package count_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam int BCD_DIGIT_W    = 4;
  localparam int BCD_ADJ_THRESH = 5;
  localparam int BCD_ADJ_ADD    = 3;

endpackage : count_pkg

// File: rtl/count_bcd_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more,
// so the following left shift carries correctly into the next decade.
module count_bcd_adj
  import count_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  always_comb begin
    if (digit_i >= BCD_DIGIT_W'(BCD_ADJ_THRESH)) begin
      digit_o = digit_i + BCD_DIGIT_W'(BCD_ADJ_ADD);
    end else begin
      digit_o = digit_i;
    end
  end

endmodule : count_bcd_adj

// File: rtl/count_bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
// with valid/ready handshakes on input and output.
module count_bcd
  import count_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DIGITS      = 3,
  parameter bit CHANGE_ONLY = 1'b0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [WIDTH-1:0]                count_in,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [BCD_DIGIT_W*DIGITS-1:0]   bcd_out,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            busy
);

  localparam int BCD_W  = BCD_DIGIT_W * DIGITS;
  localparam int ITER_W = $clog2(WIDTH + 1);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(WIDTH - 1);

  if (10 ** DIGITS <= 2 ** WIDTH) begin : g_param_check
    $error("count_bcd: DIGITS too small for WIDTH");
  end

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   bin_q, bin_d;
  logic [WIDTH-1:0]   cap_q, cap_d;
  logic [WIDTH-1:0]   last_q, last_d;
  logic               have_last_q, have_last_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [ITER_W-1:0]  iter_q, iter_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;

  logic [BCD_W-1:0]   adj_w;
  logic [BCD_W-1:0]   shifted_w;
  logic               accept_w;
  logic               drop_w;
  logic               last_iter_w;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
    count_bcd_adj u_adj (
      .digit_i (scratch_q[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_o (adj_w[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // The binary MSB enters the corrected scratch register from the right.
  assign shifted_w   = {adj_w[BCD_W-2:0], bin_q[WIDTH-1]};
  assign last_iter_w = (iter_q == ITER_LAST);
  assign drop_w      = CHANGE_ONLY && have_last_q && (count_in == last_q);
  assign accept_w    = (state_q == IDLE) && in_valid;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_w && !drop_w) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (last_iter_w) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    bin_d       = bin_q;
    cap_d       = cap_q;
    last_d      = last_q;
    have_last_d = have_last_q;
    scratch_d   = scratch_q;
    bcd_d       = bcd_q;
    iter_d      = iter_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (accept_w && !drop_w) begin
          bin_d     = count_in;
          cap_d     = count_in;
          scratch_d = '0;
          iter_d    = '0;
        end
      end
      SHIFT: begin
        scratch_d = shifted_w;
        bin_d     = bin_q << 1;
        iter_d    = iter_q + 1'b1;
        // The final shift result is published on the same edge that enters HOLD.
        if (last_iter_w) begin
          bcd_d       = shifted_w;
          last_d      = cap_q;
          have_last_d = 1'b1;
          out_valid_d = 1'b1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
        end
      end
      default: begin
        out_valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q       <= '0;
      cap_q       <= '0;
      last_q      <= '0;
      have_last_q <= 1'b0;
      scratch_q   <= '0;
      bcd_q       <= '0;
      iter_q      <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      bin_q       <= bin_d;
      cap_q       <= cap_d;
      last_q      <= last_d;
      have_last_q <= have_last_d;
      scratch_q   <= scratch_d;
      bcd_q       <= bcd_d;
      iter_q      <= iter_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign bcd_out   = bcd_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule : count_bcd
